uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among NREQ byte producers. It accepts one byte per grant through a valid/ready handshake and optionally prefixes the byte with a tag identifying the requester. It sequences the transmitter with a start pulse and waits for the transmitter's done pulse, with a timeout watchdog. It sits between on-chip producers (status, debug, data streams) and the UART TX serializer, in the same clk domain.

## Interface
- NREQ, 4, number of requesters; legal range 2..16.
- TAG_EN, 1, when 1 each payload byte is preceded by tag byte 8'hA0 | grant_id.
- TIMEOUT, 4096, clk cycles allowed in a WAIT state before abort; must be ≥ 2.

- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester byte available.
- req_data  input  8*NREQ  byte for requester i on bits [8i+7:8i].
- req_ready  output  NREQ  one-hot, one-cycle acceptance pulse.
- grant_id  output  $clog2(NREQ)  index of the requester being served; valid while busy.
- busy  output  1  high whenever state != IDLE.
- tx_start  output  1  one-cycle pulse that launches the transmitter.
- tx_data  output  8  byte for the transmitter; stable from tx_start until done or abort.
- tx_done  input  1  one-cycle pulse from the transmitter (clk domain) when its byte has finished.
- err_timeout  output  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA.
- IDLE, with any req_valid high:
  - Select the first valid index searching upward from last_grant+1, modulo NREQ.
  - Latch its byte into the payload register and its index into grant_id.
  - Pulse req_ready[index] in the next cycle.
  - Go to SEND_TAG if TAG_EN, else SEND_DATA.
- SEND_TAG and SEND_DATA last exactly one cycle.
  - tx_start = 1 in these states.
  - tx_data = tag byte in SEND_TAG, payload byte in SEND_DATA.
  - Then go to the matching WAIT state and clear the watchdog counter.
- WAIT_TAG:
  - On tx_done, go to SEND_DATA.
  - Else, on watchdog count reaching TIMEOUT-1, pulse err_timeout and go to IDLE. The payload is dropped.
- WAIT_DATA:
  - On tx_done, go to IDLE.
  - Else, on watchdog count reaching TIMEOUT-1, pulse err_timeout and go to IDLE.
- last_grant updates to grant_id on every return to IDLE, whether normal or abort.
- Requester rules:
  - Hold req_valid and req_data stable until req_ready is seen.
  - Drop req_valid (or present the next byte) in the cycle after req_ready.
  - The arbiter never samples req_* outside IDLE.
- tx_done outside the WAIT states is ignored.
- tx_done and timeout in the same cycle: tx_done wins, no err_timeout.
- Watchdog counter width: $clog2(TIMEOUT). It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE.
  - last_grant = NREQ-1, so requester 0 wins first.
  - req_ready, tx_start, err_timeout, busy: 0.
  - grant_id, tx_data: 0.
  - Watchdog counter: 0.
- rst mid-operation takes effect at the next edge. Any in-flight byte is abandoned with no err_timeout and no req_ready.
- Valid request seen in IDLE at cycle n:
  - req_ready, busy and the first tx_start all occur in cycle n+1 (SEND state).
  - The WAIT state begins at cycle n+2.
- tx_done at cycle m in WAIT_TAG gives the tx_start for the payload at cycle m+1.
- tx_done at cycle m in WAIT_DATA returns to IDLE at m+1. The next request can be accepted in the IDLE cycle m+1 and started at m+2.
- Minimum spacing between grants: 1 IDLE cycle.
- Abort timing: the WAIT state lasts exactly TIMEOUT cycles without tx_done. err_timeout is high in the last of those cycles; IDLE follows.

## Test plan
- Single request, TAG_EN=1:
  - Stimulus: req_valid=4'b0100, req_data[23:16]=8'h5A, tx_done returned 1042 cycles after each tx_start.
  - Required: req_ready=4'b0100 for one cycle; tx_data 8'hA2 then 8'h5A, two tx_start pulses; busy drops one cycle after the second tx_done.
- Fairness:
  - Stimulus: all four requesters continuously valid, 8 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3, each receiving exactly one req_ready per grant.
- Timeout:
  - Stimulus: TIMEOUT=16, tx_done never asserted.
  - Required: err_timeout pulses 16 cycles after entering WAIT_TAG; no payload tx_start; the next valid requester is granted with pointer advanced.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle while in WAIT_DATA.
  - Required: next cycle busy=0, tx_start=0, err_timeout=0; the following grant goes to requester 0.
- Spurious and colliding done:
  - Stimulus: tx_done pulses in IDLE and in a SEND state; separately, tx_done coincident with the last timeout cycle.
  - Required: the first two are ignored; the coincident case completes normally with no err_timeout.
- TAG_EN=0 latency:
  - Stimulus: request at cycle n.
  - Required: single tx_start at n+1 carrying the payload byte; idle again one cycle after tx_done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NREQ byte producers. Each grant moves one byte (optionally preceded by a
// tag byte 8'hA0 | grant_id) through the transmitter using a start/done
// exchange guarded by a watchdog.
//
// Requester handshake: a requester raises req_valid[i] with req_data[i]
// and holds both stable until it sees req_ready[i]. req_ready is a one-cycle,
// one-hot pulse that marks the byte as taken; in the next cycle the requester
// either drops req_valid[i] or presents its next byte. Inputs are sampled only
// in IDLE, so anything presented while busy simply waits.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TAG_EN  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic                    err_timeout
);

  localparam int GW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_TAG,
    S_WAIT_TAG,
    S_SEND_DATA,
    S_WAIT_DATA
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [GW-1:0]   last_grant;
  logic [7:0]      payload;
  logic [WW-1:0]   wd_cnt;
  logic            wd_expired;

  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  logic [GW-1:0]   cand;
  logic [7:0]      sel_byte;
  logic [7:0]      sel_tag;

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NREQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_byte = req_data[{sel_idx, 3'b000} +: 8];
    sel_tag  = 8'hA0 | 8'(sel_idx);
  end

  assign wd_expired = (wd_cnt == WD_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state outputs; tx_done wins over a coincident timeout.
  always_comb begin
    state_next  = state;
    busy        = 1'b1;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (sel_found) begin
          state_next = (TAG_EN != 0) ? S_SEND_TAG : S_SEND_DATA;
        end
      end
      S_SEND_TAG: begin
        tx_start   = 1'b1;
        state_next = S_WAIT_TAG;
      end
      S_WAIT_TAG: begin
        if (tx_done) begin
          state_next = S_SEND_DATA;
        end else if (wd_expired) begin
          err_timeout = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_SEND_DATA: begin
        tx_start   = 1'b1;
        state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (tx_done) begin
          state_next = S_IDLE;
        end else if (wd_expired) begin
          err_timeout = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Grant capture, transmit byte, acceptance pulse, watchdog and RR pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(NREQ - 1);
      grant_id   <= '0;
      payload    <= '0;
      tx_data    <= '0;
      req_ready  <= '0;
      wd_cnt     <= '0;
    end else begin
      req_ready <= '0;
      if (state == S_IDLE && sel_found) begin
        grant_id  <= sel_idx;
        payload   <= sel_byte;
        req_ready <= NREQ'(1) << sel_idx;
        tx_data   <= (TAG_EN != 0) ? sel_tag : sel_byte;
      end
      if (state == S_WAIT_TAG && tx_done) begin
        tx_data <= payload;
      end
      // The watchdog restarts on every launch and saturates rather than wraps.
      if (state == S_SEND_TAG || state == S_SEND_DATA) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT_TAG || state == S_WAIT_DATA) && !wd_expired) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
      // The pointer moves on every return to IDLE, including aborts.
      if (state != S_IDLE && state_next == S_IDLE) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of uart_tx_arbiter using three
// configurations: tagged with a long watchdog (a), tagged with TIMEOUT=16 (b)
// and untagged with TIMEOUT=16 (c). All share clk, rst and the request bus.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;

  logic [3:0]  req_ready_a, req_ready_b, req_ready_c;
  logic [1:0]  grant_id_a, grant_id_b, grant_id_c;
  logic        busy_a, busy_b, busy_c;
  logic        tx_start_a, tx_start_b, tx_start_c;
  logic [7:0]  tx_data_a, tx_data_b, tx_data_c;
  logic        err_a, err_b, err_c;
  logic        tx_done_a = 1'b0, tx_done_b = 1'b0, tx_done_c = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_start_a, cnt_err_a, cnt_start_b, cnt_err_b;
  int rr_cnt[4];
  logic [1:0] exp_q[$];
  logic [7:0] pay[4];

  uart_tx_arbiter #(.NREQ(4), .TAG_EN(1), .TIMEOUT(4096)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_a), .grant_id(grant_id_a), .busy(busy_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_done(tx_done_a),
    .err_timeout(err_a)
  );

  uart_tx_arbiter #(.NREQ(4), .TAG_EN(1), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .grant_id(grant_id_b), .busy(busy_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_done(tx_done_b),
    .err_timeout(err_b)
  );

  uart_tx_arbiter #(.NREQ(4), .TAG_EN(0), .TIMEOUT(16)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_c), .grant_id(grant_id_c), .busy(busy_c),
    .tx_start(tx_start_c), .tx_data(tx_data_c), .tx_done(tx_done_c),
    .err_timeout(err_c)
  );

  // Clock and run-time limit.
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL run_limit: got timeout expected finish");
    $fatal(1, "run limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge; tx_done defaults low each cycle.
  task automatic step();
    @(posedge clk);
    #1;
    tx_done_a = 1'b0;
    tx_done_b = 1'b0;
    tx_done_c = 1'b0;
  endtask

  // Sample on the falling edge and accumulate event counters.
  task automatic sample();
    @(negedge clk);
    cnt_start_a += int'(tx_start_a);
    cnt_err_a   += int'(err_a);
    cnt_start_b += int'(tx_start_b);
    cnt_err_b   += int'(err_b);
    for (int i = 0; i < 4; i++) rr_cnt[i] += int'(req_ready_a[i]);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      sample();
    end
  endtask

  task automatic clear_counts();
    cnt_start_a = 0;
    cnt_err_a   = 0;
    cnt_start_b = 0;
    cnt_err_b   = 0;
    for (int i = 0; i < 4; i++) rr_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
    clear_counts();
  endtask

  initial begin
    int w;
    logic [1:0] e;

    // Single request, tagged, done returned 1042 cycles after each start.
    do_reset();
    req_valid = 4'b0100;
    req_data  = {8'h44, 8'h5A, 8'h22, 8'h11};
    sample();
    check("rst_busy", busy_a, 0);
    check("rst_ready", req_ready_a, 0);
    check("rst_start", tx_start_a, 0);
    check("rst_err", err_a, 0);
    check("rst_grant", grant_id_a, 0);
    check("rst_txdata", tx_data_a, 0);
    step(); sample();
    check("t1_ready", req_ready_a, 4'b0100);
    check("t1_start_tag", tx_start_a, 1);
    check("t1_tag", tx_data_a, 8'hA2);
    check("t1_busy", busy_a, 1);
    check("t1_grant", grant_id_a, 2);
    step(); req_valid = '0; sample();
    check("t1_ready_once", req_ready_a, 0);
    check("t1_start_once", tx_start_a, 0);
    clear_counts();
    run(1040);
    step(); tx_done_a = 1'b1; sample();
    check("t1_wait_starts", cnt_start_a, 0);
    check("t1_busy_wait", busy_a, 1);
    step(); sample();
    check("t1_start_data", tx_start_a, 1);
    check("t1_data", tx_data_a, 8'h5A);
    clear_counts();
    run(1041);
    step(); tx_done_a = 1'b1; sample();
    check("t1_busy_last", busy_a, 1);
    check("t1_extra_starts", cnt_start_a, 0);
    step(); sample();
    check("t1_idle", busy_a, 0);
    check("t1_no_err", cnt_err_a, 0);

    // Fairness: all four requesters valid for eight transactions.
    do_reset();
    pay[0] = 8'h10; pay[1] = 8'h21; pay[2] = 8'h32; pay[3] = 8'h43;
    req_valid = 4'b1111;
    req_data  = {pay[3], pay[2], pay[1], pay[0]};
    for (int k = 0; k < 8; k++) exp_q.push_back(2'(k % 4));
    sample();
    for (int t = 0; t < 8; t++) begin
      e = exp_q.pop_front();
      w = 0;
      do begin
        step(); sample();
        w++;
      end while (req_ready_a == 0 && w < 8);
      check("fair_ready", req_ready_a, 4'(1) << e);
      check("fair_grant", grant_id_a, e);
      check("fair_tag", tx_data_a, 8'hA0 | 8'(e));
      step(); tx_done_a = 1'b1; sample();
      step(); sample();
      check("fair_data", tx_data_a, pay[e]);
      step(); tx_done_a = 1'b1; sample();
      step(); sample();
      check("fair_idle", busy_a, 0);
    end
    for (int i = 0; i < 4; i++) check("fair_count", rr_cnt[i], 2);

    // Watchdog abort in WAIT_TAG with TIMEOUT=16.
    do_reset();
    req_valid = 4'b0011;
    req_data  = {8'h00, 8'h00, 8'hB1, 8'hB0};
    sample();
    step(); sample();
    check("to_ready", req_ready_b, 4'b0001);
    check("to_tag", tx_data_b, 8'hA0);
    step(); sample();
    check("to_err_first", err_b, 0);
    clear_counts();
    run(14);
    check("to_err_early", cnt_err_b, 0);
    step(); sample();
    check("to_err_pulse", err_b, 1);
    check("to_busy_last", busy_b, 1);
    step(); sample();
    check("to_idle", busy_b, 0);
    check("to_err_once", err_b, 0);
    check("to_no_payload", cnt_start_b, 0);
    step(); sample();
    check("to_next_ready", req_ready_b, 4'b0010);
    check("to_next_grant", grant_id_b, 1);
    check("to_next_tag", tx_data_b, 8'hA1);

    // Reset while in WAIT_DATA.
    do_reset();
    req_valid = 4'b0100;
    req_data  = {8'h44, 8'h5A, 8'h22, 8'h11};
    sample();
    step(); sample();
    step(); req_valid = '0; tx_done_a = 1'b1; sample();
    step(); sample();
    step(); sample();
    check("mr_in_wait", busy_a, 1);
    step(); rst = 1'b1; sample();
    step(); rst = 1'b0; req_valid = 4'b1111; sample();
    check("mr_busy", busy_a, 0);
    check("mr_start", tx_start_a, 0);
    check("mr_err", err_a, 0);
    check("mr_ready", req_ready_a, 0);
    step(); sample();
    check("mr_regrant", req_ready_a, 4'b0001);
    check("mr_grant", grant_id_a, 0);

    // Spurious tx_done in IDLE and in SEND_TAG.
    do_reset();
    req_data = {8'h00, 8'h00, 8'h00, 8'h77};
    sample();
    step(); tx_done_a = 1'b1; sample();
    check("sp_idle_busy", busy_a, 0);
    check("sp_idle_start", tx_start_a, 0);
    step(); req_valid = 4'b0001; sample();
    step(); tx_done_a = 1'b1; sample();
    check("sp_send_start", tx_start_a, 1);
    step(); req_valid = '0; sample();
    check("sp_wait_a", tx_start_a, 0);
    step(); sample();
    check("sp_wait_b", tx_start_a, 0);
    check("sp_wait_busy", busy_a, 1);
    step(); tx_done_a = 1'b1; sample();
    step(); sample();
    check("sp_data_start", tx_start_a, 1);
    check("sp_data", tx_data_a, 8'h77);

    // tx_done coincident with the last watchdog cycle.
    do_reset();
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'h00, 8'h66};
    sample();
    step(); sample();
    step(); req_valid = '0; sample();
    clear_counts();
    run(14);
    step(); tx_done_b = 1'b1; sample();
    check("co_no_err", err_b, 0);
    check("co_err_count", cnt_err_b, 0);
    step(); sample();
    check("co_start", tx_start_b, 1);
    check("co_data", tx_data_b, 8'h66);

    // Untagged latency.
    do_reset();
    req_valid = 4'b1000;
    req_data  = {8'h9C, 8'h00, 8'h00, 8'h00};
    sample();
    step(); sample();
    check("nt_ready", req_ready_c, 4'b1000);
    check("nt_start", tx_start_c, 1);
    check("nt_data", tx_data_c, 8'h9C);
    check("nt_grant", grant_id_c, 3);
    step(); req_valid = '0; sample();
    check("nt_single", tx_start_c, 0);
    check("nt_wait_busy", busy_c, 1);
    step(); tx_done_c = 1'b1; sample();
    step(); sample();
    check("nt_idle", busy_c, 0);
    check("nt_idle_start", tx_start_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
